// File: rtl/stack_access_unit_pkg.sv
// Shared stack definitions: FSM state encoding and the default stack geometry.
// The SP register and the memory map use the same geometry defaults.
package stack_access_unit_pkg;

    localparam int          DATA_W_DEF      = 16;
    localparam int          SP_STEP_DEF     = 2;
    localparam logic [15:0] STACK_TOP_DEF   = 16'hFFFE;
    localparam logic [15:0] STACK_LIMIT_DEF = 16'hF000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_WR = 2'd1,
        POP_RD  = 2'd2,
        COMMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/stack_access_unit.sv
// Push/pop sequencer for a full-descending stack: drives data memory and the SP register update.
// Optional bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_access_unit
    import stack_access_unit_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SP_STEP = SP_STEP_DEF
`ifdef STACK_BOUNDS_CHECK_EN
    ,
    parameter logic [DATA_W-1:0] STACK_TOP   = STACK_TOP_DEF,
    parameter logic [DATA_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic [DATA_W-1:0] sp_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              sp_write,
    output logic [DATA_W-1:0] sp_next,
    output logic [DATA_W-1:0] pop_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output state_t            dbg_state
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(SP_STEP);

    state_t            state_q;
    logic [DATA_W-1:0] addr_q, data_q, sp_next_q, pop_data_q;
    logic              mem_read_q, mem_write_q, sp_write_q, done_q, err_q;

    logic [DATA_W-1:0] push_addr_d, pop_next_d;
    logic              push_reject_d, pop_reject_d;

    assign push_addr_d = sp_in - STEP;
    assign pop_next_d  = sp_in + STEP;

`ifdef STACK_BOUNDS_CHECK_EN
    assign push_reject_d = (push_addr_d < STACK_LIMIT) || (sp_in < STEP);
    assign pop_reject_d  = (sp_in >= STACK_TOP);
`else
    assign push_reject_d = 1'b0;
    assign pop_reject_d  = 1'b0;
`endif

    // Memory handshake: a strobe stays high until mem_ready is sampled high on a
    // rising clock edge; that edge completes the access and drops the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            sp_next_q   <= '0;
            pop_data_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            sp_write_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        if (push_reject_d) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= COMMIT;
                        end else begin
                            addr_q      <= push_addr_d;
                            data_q      <= push_data;
                            mem_write_q <= 1'b1;
                            state_q     <= PUSH_WR;
                        end
                    end else if (pop) begin
                        if (pop_reject_d) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= COMMIT;
                        end else begin
                            addr_q     <= sp_in;
                            sp_next_q  <= pop_next_d;
                            mem_read_q <= 1'b1;
                            state_q    <= POP_RD;
                        end
                    end
                end
                PUSH_WR: begin
                    if (mem_ready) begin
                        mem_write_q <= 1'b0;
                        sp_next_q   <= addr_q;
                        sp_write_q  <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= COMMIT;
                    end
                end
                POP_RD: begin
                    if (mem_ready) begin
                        mem_read_q <= 1'b0;
                        pop_data_q <= mem_rdata;
                        sp_write_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= COMMIT;
                    end
                end
                COMMIT: begin
                    sp_write_q <= 1'b0;
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign sp_write  = sp_write_q;
    assign sp_next   = sp_next_q;
    assign pop_data  = pop_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
`ifdef STACK_BOUNDS_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_access_unit.sv
// Randomized bench for stack_access_unit: the bench plays data memory and checks each
// transaction against a transaction-level stack model (honours STACK_BOUNDS_CHECK_EN).
module tb_stack_access_unit;
    import stack_access_unit_pkg::*;

    localparam logic [15:0] STEP  = 16'(SP_STEP_DEF);
    localparam logic [15:0] TOP   = STACK_TOP_DEF;
    localparam logic [15:0] LIMIT = STACK_LIMIT_DEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        push, pop, mem_ready;
    logic [15:0] push_data, sp_in, mem_rdata;
    logic [15:0] mem_addr, mem_wdata, sp_next, pop_data;
    logic        mem_read, mem_write, sp_write, busy, done, err;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_model [logic [15:0]];
    logic [15:0] model_sp;
    logic [15:0] exp_pop;

    stack_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .sp_in     (sp_in),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .sp_write  (sp_write),
        .sp_next   (sp_next),
        .pop_data  (pop_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_junk();
        push      = 1'($urandom_range(0, 1));
        pop       = 1'($urandom_range(0, 1));
        push_data = 16'($urandom);
        sp_in     = 16'($urandom);
    endtask

    // One request issued at the current negedge; every cycle up to the return to idle is checked.
    task automatic do_op(input logic p_push, input logic p_pop, input logic [15:0] p_data,
                         input logic [15:0] p_sp, input int waits);
        logic        is_push, rej;
        logic [15:0] e_addr, e_next, rd_val;
        is_push = p_push;
        rej     = 1'b0;
        rd_val  = '0;
        if (is_push) begin
            e_addr = p_sp - STEP;
            e_next = e_addr;
`ifdef STACK_BOUNDS_CHECK_EN
            rej = (e_addr < LIMIT) || (p_sp < STEP);
`endif
        end else begin
            e_addr = p_sp;
            e_next = p_sp + STEP;
`ifdef STACK_BOUNDS_CHECK_EN
            rej = (p_sp >= TOP);
`endif
        end
        push = p_push; pop = p_pop; push_data = p_data; sp_in = p_sp; mem_ready = 1'b0;
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        if (rej) begin
            check("rej_busy", busy, 1);
            check("rej_done", done, 1);
            check("rej_err", err, 1);
            check("rej_spw", sp_write, 0);
            check("rej_strobe", {mem_read, mem_write}, 0);
            check("rej_pop_data", pop_data, exp_pop);
            drive_junk();
            @(negedge clk);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                if (i > 0) @(negedge clk);
                check("acc_write", mem_write, is_push);
                check("acc_read", mem_read, !is_push);
                check("acc_addr", mem_addr, e_addr);
                if (is_push) check("acc_wdata", mem_wdata, p_data);
                check("acc_done", done, 0);
                check("acc_spw", sp_write, 0);
                check("acc_busy", busy, 1);
                drive_junk();
                mem_ready = (i == waits);
                mem_rdata = 16'($urandom);
                if (i == waits) begin
                    if (is_push) mem_model[e_addr] = p_data;
                    else begin
                        if (!mem_model.exists(e_addr)) mem_model[e_addr] = 16'($urandom);
                        rd_val    = mem_model[e_addr];
                        mem_rdata = rd_val;
                    end
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            if (!is_push) exp_pop = rd_val;
            check("cmt_spw", sp_write, 1);
            check("cmt_done", done, 1);
            check("cmt_err", err, 0);
            check("cmt_sp_next", sp_next, e_next);
            check("cmt_strobe", {mem_read, mem_write}, 0);
            check("cmt_pop_data", pop_data, exp_pop);
            drive_junk();
            model_sp = e_next;
            @(negedge clk);
        end
        push = 1'b0; pop = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_spw", sp_write, 0);
        check("idle_pop_data", pop_data, exp_pop);
    endtask

    logic [15:0] edge_sp [7];

    initial begin
        edge_sp = '{16'h0000, 16'h0002, 16'hF000, 16'hF002, 16'hFFFE, 16'hFFFC, 16'h1000};
        reset = 1'b1; push = 1'b0; pop = 1'b0; mem_ready = 1'b0;
        push_data = '0; sp_in = '0; mem_rdata = '0;
        exp_pop = '0; model_sp = TOP;
        #1;
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_sp_next", sp_next, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_strobes", {mem_read, mem_write, sp_write}, 0);
        check("rst_flags", {busy, done, err}, 0);
        check("rst_state", dbg_state, IDLE);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        do_op(1'b1, 1'b0, 16'hABCD, 16'hFFFE, 0);
        mem_model[16'hFFFC] = 16'h1234;
        do_op(1'b0, 1'b1, 16'h0000, 16'hFFFC, 2);
        do_op(1'b1, 1'b1, 16'h0001, 16'hFFFE, 1);
        do_op(1'b0, 1'b1, 16'h0000, 16'hFFFE, 0);
        do_op(1'b1, 1'b0, 16'h7777, 16'hF000, 0);
        do_op(1'b1, 1'b0, 16'h5555, 16'h0000, 0);
        do_op(1'b1, 1'b0, 16'h6666, 16'hF002, 0);
        do_op(1'b0, 1'b1, 16'h0000, 16'hF000, 1);

        // Random traffic, mostly following the modelled SP register.
        model_sp = TOP;
        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [15:0] sp;
            kind = $urandom_range(0, 9);
            sp   = ($urandom_range(0, 3) != 0) ? model_sp : edge_sp[$urandom_range(0, 6)];
            do_op(kind < 5 || kind == 9, kind >= 5, 16'($urandom), sp, $urandom_range(0, 3));
        end

        // Reset in the middle of a push write.
        push = 1'b1; push_data = 16'h5A5A; sp_in = 16'hFFF0;
        @(negedge clk);
        push = 1'b0;
        check("pre_rst_write", mem_write, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_write", mem_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pop_data", pop_data, 0);
        check("mid_rst_spw", sp_write, 0);
        exp_pop = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_spw", sp_write, 0);
            check("post_rst_done", done, 0);
            check("post_rst_write", mem_write, 0);
        end
        do_op(1'b1, 1'b0, 16'hC0DE, 16'hFFFE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
